// File: rtl/uv_queue_reader_if.sv
// Bundles the queue read channel, the narrow beat stream and the flush/status
// signals of uv_queue_reader. The master modport is the reader's view.
interface uv_queue_reader_if #(
  parameter int DAT_WIDTH  = 32,
  parameter int BEAT_WIDTH = 8
);
  logic                  que_rd_rdy;
  logic                  que_rd_vld;
  logic [DAT_WIDTH-1:0]  que_rd_dat;
  logic                  out_vld;
  logic                  out_rdy;
  logic [BEAT_WIDTH-1:0] out_dat;
  logic                  out_last;
  logic                  clr;
  logic                  busy;

  modport master (
    input  que_rd_rdy, que_rd_dat, out_rdy, clr,
    output que_rd_vld, out_vld, out_dat, out_last, busy
  );

  modport slave (
    output que_rd_rdy, que_rd_dat, out_rdy, clr,
    input  que_rd_vld, out_vld, out_dat, out_last, busy
  );
endinterface

// File: rtl/uv_queue_reader.sv
// Read-side master for a uv_queue: pops DAT_WIDTH words and serializes each
// into DAT_WIDTH/BEAT_WIDTH beats on a valid/ready stream with a last flag.
module uv_queue_reader #(
  parameter int   DAT_WIDTH  = 32,
  parameter int   BEAT_WIDTH = 8,
  parameter logic ZERO_RDLY  = 1'b1,
  parameter logic LSB_FIRST  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  uv_queue_reader_if.master  bus
);
  localparam int BEATS = DAT_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      beat_cnt_reg;
  logic [DAT_WIDTH-1:0]  word_reg;

  logic                  send;
  logic                  beat_last;
  logic                  xfer;
  logic                  pop;
  logic [CNT_W-1:0]      beat_sel;
  logic [BEAT_WIDTH-1:0] beat_mux;
  logic [BEAT_WIDTH-1:0] beat_arr [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_arr[gi] = word_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end
  endgenerate

  assign send      = (state_reg == ST_SEND);
  assign beat_last = send && (beat_cnt_reg == LAST_CNT);
  assign xfer      = send && bus.out_rdy;
  assign beat_sel  = LSB_FIRST ? beat_cnt_reg : (LAST_CNT - beat_cnt_reg);

  // Pop is gated by rst so no word is lost while the reader is held in reset.
  assign pop = bus.que_rd_rdy && !bus.clr && !rst &&
               ((state_reg == ST_IDLE) || (xfer && beat_last));

  always_comb begin
    beat_mux = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_sel == CNT_W'(i)) beat_mux = beat_arr[i];
    end
  end

  assign bus.que_rd_vld = pop;
  assign bus.out_vld    = send;
  assign bus.out_last   = beat_last;
  assign bus.out_dat    = send ? beat_mux : '0;
  assign bus.busy       = (state_reg != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      word_reg     <= '0;
    end else if (bus.clr) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            if (ZERO_RDLY) begin
              word_reg     <= bus.que_rd_dat;
              beat_cnt_reg <= '0;
              state_reg    <= ST_SEND;
            end else begin
              state_reg    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          word_reg     <= bus.que_rd_dat;
          beat_cnt_reg <= '0;
          state_reg    <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            if (!beat_last) begin
              beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end else if (pop) begin
              // Zero-latency queues reload in place so words stream back to back.
              if (ZERO_RDLY) begin
                word_reg     <= bus.que_rd_dat;
                beat_cnt_reg <= '0;
              end else begin
                state_reg    <= ST_WAIT;
              end
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
